// File: rtl/shift_sequencer_if.sv
// Request/response bundle for shift_sequencer: two request ports and one tagged response port.
// The master side issues requests and consumes results; the slave side is the sequencer.
interface shift_sequencer_if #(
    parameter int BUS_WIDTH      = 8,
    parameter int BUS_WIDTH_BITS = 3
);
    logic                      req0_valid;
    logic                      req0_ready;
    logic [2:0]                req0_op;
    logic [BUS_WIDTH-1:0]      req0_a;
    logic [BUS_WIDTH_BITS-1:0] req0_amt;

    logic                      req1_valid;
    logic                      req1_ready;
    logic [2:0]                req1_op;
    logic [BUS_WIDTH-1:0]      req1_a;
    logic [BUS_WIDTH_BITS-1:0] req1_amt;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [BUS_WIDTH-1:0]      rsp_data;
    logic                      rsp_id;
    logic                      rsp_err;

    modport master (
        output req0_valid, req0_op, req0_a, req0_amt,
        output req1_valid, req1_op, req1_a, req1_amt,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id, rsp_err
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_amt,
        input  req1_valid, req1_op, req1_a, req1_amt,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id, rsp_err
    );
endinterface

// File: rtl/shift_sequencer.sv
// Two-requester round-robin controller that reuses one shifter over one or two passes
// to build shifts, rotates and arithmetic right shifts, returning id-tagged results.
module shift_sequencer #(
    parameter int BUS_WIDTH      = 8,
    parameter int BUS_WIDTH_BITS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] OP_SHL = 3'd0;
    localparam logic [2:0] OP_SHR = 3'd1;
    localparam logic [2:0] OP_ROL = 3'd2;
    localparam logic [2:0] OP_ROR = 3'd3;
    localparam logic [2:0] OP_ASR = 3'd4;
    localparam logic [BUS_WIDTH_BITS-1:0] WIDTH_MOD = BUS_WIDTH_BITS'(BUS_WIDTH);

    // Shared shifter: b = {dir, amt}, dir = 1 shifts left.
    function automatic logic [BUS_WIDTH-1:0] logic_shift(
        input logic [BUS_WIDTH-1:0]  a,
        input logic [BUS_WIDTH_BITS:0] b
    );
        if (b[BUS_WIDTH_BITS]) begin
            return a << b[BUS_WIDTH_BITS-1:0];
        end else begin
            return a >> b[BUS_WIDTH_BITS-1:0];
        end
    endfunction

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [2:0]                r_op;
    logic [BUS_WIDTH-1:0]      r_a;
    logic [BUS_WIDTH_BITS-1:0] r_amt;
    logic                      r_id;
    logic [BUS_WIDTH-1:0]      r_acc;
    logic                      r_err;
    logic                      r_last_grant;
    logic                      r_rsp_valid;
    logic [BUS_WIDTH-1:0]      r_rsp_data;
    logic                      r_rsp_id;
    logic                      r_rsp_err;

    logic                      w_ready0;
    logic                      w_ready1;
    logic                      w_accept;
    logic                      w_reserved;
    logic [BUS_WIDTH_BITS-1:0] w_n2;
    logic [BUS_WIDTH-1:0]      w_sh_a;
    logic                      w_sh_dir;
    logic [BUS_WIDTH_BITS-1:0] w_sh_amt;
    logic [BUS_WIDTH-1:0]      w_sh_y;

    assign w_reserved = (r_op > OP_ASR);
    assign w_n2       = WIDTH_MOD - r_amt;
    assign w_sh_y     = logic_shift(w_sh_a, {w_sh_dir, w_sh_amt});

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_PASS1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PASS1: begin
                if ((r_op == OP_ROL) || (r_op == OP_ROR) || (r_op == OP_ASR)) begin
                    w_state_nxt = ST_PASS2;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_PASS2: w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (r_rsp_valid && bus.rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: round-robin readys and shifter control for the current pass.
    always_comb begin
        w_ready0 = rst_n && (r_state == ST_IDLE) && bus.req0_valid
                   && (!bus.req1_valid || r_last_grant);
        w_ready1 = rst_n && (r_state == ST_IDLE) && bus.req1_valid
                   && (!bus.req0_valid || !r_last_grant);
        w_accept = w_ready0 || w_ready1;
        w_sh_a   = r_a;
        w_sh_dir = 1'b0;
        w_sh_amt = r_amt;
        case (r_state)
            ST_PASS1: w_sh_dir = (r_op == OP_SHL) || (r_op == OP_ROL);
            ST_PASS2: begin
                case (r_op)
                    OP_ROL: w_sh_amt = w_n2;
                    OP_ROR: begin
                        w_sh_dir = 1'b1;
                        w_sh_amt = w_n2;
                    end
                    OP_ASR: w_sh_a = '1;
                    default: w_sh_a = r_a;
                endcase
            end
            default: w_sh_a = r_a;
        endcase
    end

    // Request capture, accumulator passes and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op         <= 3'd0;
            r_a          <= '0;
            r_amt        <= '0;
            r_id         <= 1'b0;
            r_acc        <= '0;
            r_err        <= 1'b0;
            r_last_grant <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_id     <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op         <= w_ready0 ? bus.req0_op  : bus.req1_op;
                        r_a          <= w_ready0 ? bus.req0_a   : bus.req1_a;
                        r_amt        <= w_ready0 ? bus.req0_amt : bus.req1_amt;
                        r_id         <= w_ready1;
                        r_last_grant <= w_ready1;
                    end
                end
                ST_PASS1: begin
                    r_acc <= w_reserved ? '0 : w_sh_y;
                    r_err <= w_reserved;
                end
                ST_PASS2: begin
                    case (r_op)
                        OP_ROL, OP_ROR: r_acc <= r_acc | w_sh_y;
                        OP_ASR: begin
                            // Sign fill: the bits the mask shifted out become ones.
                            if (r_a[BUS_WIDTH-1]) begin
                                r_acc <= r_acc | ~w_sh_y;
                            end
                        end
                        default: r_acc <= r_acc;
                    endcase
                end
                ST_RESP: begin
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_acc;
                        r_rsp_id    <= r_id;
                        r_rsp_err   <= r_err;
                    end else if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: r_rsp_valid <= 1'b0;
            endcase
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_err    = r_rsp_err;
endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases, arbitration, reset behaviour
// and randomized transactions compared against an arithmetic reference model.
module tb_shift_sequencer;
    localparam int W  = 8;
    localparam int WB = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    shift_sequencer_if #(.BUS_WIDTH(W), .BUS_WIDTH_BITS(WB)) bus ();

    shift_sequencer #(.BUS_WIDTH(W), .BUS_WIDTH_BITS(WB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result {err, data} from plain integer arithmetic.
    function automatic logic [8:0] ref_result(input int op, input int a, input int amt);
        int   r;
        int   sa;
        logic e;
        e = 1'b0;
        case (op)
            0: r = (a << amt) & 255;
            1: r = a >> amt;
            2: r = ((a << amt) | (a >> (8 - amt))) & 255;
            3: r = ((a >> amt) | (a << (8 - amt))) & 255;
            4: begin
                sa = (a > 127) ? a - 256 : a;
                r  = (sa >>> amt) & 255;
            end
            default: begin
                r = 0;
                e = 1'b1;
            end
        endcase
        return {e, r[7:0]};
    endfunction

    function automatic logic port_ready(input int port);
        return (port == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction

    task automatic drive(input int port, input logic v, input int op, input int a, input int amt);
        if (port == 0) begin
            bus.req0_valid = v;
            bus.req0_op    = 3'(op);
            bus.req0_a     = 8'(a);
            bus.req0_amt   = 3'(amt);
        end else begin
            bus.req1_valid = v;
            bus.req1_op    = 3'(op);
            bus.req1_a     = 8'(a);
            bus.req1_amt   = 3'(amt);
        end
    endtask

    task automatic wait_rsp();
        int k;
        k = 0;
        while (!bus.rsp_valid && k < 12) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rsp_timeout", {31'd0, bus.rsp_valid}, 32'd1);
    endtask

    // One request on one port, latency measured from the accept edge, optional back-pressure.
    task automatic txn(input int port, input int op, input int a, input int amt, input int stall);
        logic [8:0] exp;
        int         k;
        int         lat;
        exp = ref_result(op, a, amt);
        @(negedge clk);
        drive(port, 1'b1, op, a, amt);
        #1;
        k = 0;
        while (!port_ready(port) && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        chk("accept", {31'd0, port_ready(port)}, 32'd1);
        @(posedge clk); #1;
        drive(port, 1'b0, op, a, amt);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.rsp_valid && lat < 10);
        chk("latency", lat, (op >= 2 && op <= 4) ? 32'd3 : 32'd2);
        chk("data", {24'd0, bus.rsp_data}, {23'd0, 1'b0, exp[7:0]});
        chk("id", {31'd0, bus.rsp_id}, port);
        chk("err", {31'd0, bus.rsp_err}, {31'd0, exp[8]});
        for (int s = 0; s < stall; s++) begin
            drive(0, 1'b1, 0, 8'h5A, 1);
            drive(1, 1'b1, 1, 8'hA5, 2);
            #1;
            chk("stall_rdy", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
            chk("stall_hold", {21'd0, bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data},
                {21'd0, 1'b1, 1'(port), exp});
            @(posedge clk); #1;
        end
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("rsp_drop", {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    initial begin
        drive(0, 1'b1, 0, 0, 0);
        drive(1, 1'b1, 0, 0, 0);
        bus.rsp_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out", {21'd0, bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data}, 32'd0);
        chk("rst_rdy", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        rst_n = 1'b1;

        txn(0, 0, 8'h81, 3, 0);
        txn(0, 1, 8'h81, 7, 0);
        txn(1, 3, 8'h96, 4, 0);
        txn(1, 2, 8'h81, 1, 0);
        txn(0, 2, 8'h81, 0, 0);
        txn(0, 4, 8'h90, 2, 0);
        txn(1, 4, 8'h70, 2, 0);
        txn(0, 4, 8'h80, 7, 0);
        txn(0, 5, 8'hAA, 0, 5);
        txn(1, 0, 8'hC3, 1, 0);

        // Reset during the second pass of a rotate.
        @(negedge clk);
        drive(0, 1'b1, 3, 8'h96, 4);
        #1;
        chk("pre_rst_accept", {31'd0, bus.req0_ready}, 32'd1);
        @(posedge clk); #1;
        drive(0, 1'b0, 0, 0, 0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        drive(0, 1'b1, 0, 8'h11, 1);
        drive(1, 1'b1, 0, 8'h05, 2);
        #1;
        chk("midrst_out", {21'd0, bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data}, 32'd0);
        chk("midrst_rdy", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        rst_n = 1'b1;

        // Both requesters held valid: grants alternate starting with req0.
        for (int i = 0; i < 4; i++) begin
            wait_rsp();
            chk("arb_id", {31'd0, bus.rsp_id}, i % 2);
            chk("arb_data", {24'd0, bus.rsp_data}, (i % 2 == 0) ? 32'h22 : 32'h14);
            @(posedge clk); #1;
        end
        drive(0, 1'b0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            wait_rsp();
            chk("solo_id", {31'd0, bus.rsp_id}, 32'd1);
            @(posedge clk); #1;
        end
        drive(1, 1'b0, 0, 0, 0);
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);

        for (int n = 0; n < 40; n++) begin
            txn(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle controller that shares one `logic_shift` instance between two requesters and sequences it to provide shift, rotate and arithmetic-shift operations. Requests arrive on two valid/ready ports and are granted round-robin. Each request takes one or two passes through the shifter. Results leave on a single valid/ready response port tagged with the requester id. The block sits between the ALU operand/issue logic and the writeback path.

## Interface
- `BUS_WIDTH`, 8, operand and result width; must equal 2**`BUS_WIDTH_BITS`.
- `BUS_WIDTH_BITS`, 3, width of the shift-amount field.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when valid && ready.
- `req0_op` / `req1_op`  in  3  000 SHL, 001 SHR, 010 ROL, 011 ROR, 100 ASR, 101–111 reserved.
- `req0_a` / `req1_a`  in  BUS_WIDTH  operand.
- `req0_amt` / `req1_amt`  in  BUS_WIDTH_BITS  shift amount, 0..BUS_WIDTH-1.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result when valid && ready.
- `rsp_data`  out  BUS_WIDTH  result.
- `rsp_id`  out  1  requester index, 0 or 1.
- `rsp_err`  out  1  reserved opcode flag.

## Operation
- Shifter control: one internal `logic_shift` instance.
  - B = {dir, amt}; dir = 1 selects left, dir = 0 selects right.
  - The shifter is combinational. Its output is registered into accumulator `acc`.
- FSM states: IDLE, PASS1, PASS2, RESP.
  - IDLE: the granted requester sees ready = 1. On accept, the FSM captures op, a, amt and id, then goes to PASS1.
  - PASS1: drives the shifter with the pass-1 setting below and loads `acc`.
    - SHL: a << amt.
    - SHR: a >> amt.
    - ROL: a << amt.
    - ROR: a >> amt.
    - ASR: a >> amt.
    - Reserved: `acc` = 0 and `err` = 1.
  - PASS1 exit: SHL, SHR and reserved go to RESP; ROL, ROR and ASR go to PASS2.
  - PASS2: drives the shifter again, with n2 = (BUS_WIDTH − amt) mod 2**BUS_WIDTH_BITS.
    - ROL: acc | (a >> n2).
    - ROR: acc | (a << n2).
    - ASR: shift an all-ones mask right by amt. If a[MSB] = 1, acc | ~mask; otherwise acc unchanged.
    - Then go to RESP.
  - Amount 0: n2 = 0, so both rotates return a unchanged.
  - RESP: `rsp_valid` = 1, with `rsp_data`, `rsp_id` and `rsp_err` driven from registers. On rsp_ready, go to IDLE.
- Arbitration: round-robin using register `last_grant`, reset value 1, so req0 wins first.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester ≠ `last_grant` is granted.
  - `last_grant` updates only on an accept.
  - Both readys are 0 in every state other than IDLE, and while rst_n = 0.
- Ready may depend combinationally on the valids. Valid must not depend on ready.
- Requests must hold op, a and amt stable while valid && !ready. The block samples them only on the accept edge.

## Timing
- Latency from the accept edge E:
  - Single-pass ops (SHL, SHR, reserved): `rsp_valid` rises after edge E+2.
  - Two-pass ops (ROL, ROR, ASR): `rsp_valid` rises after edge E+3.
- Throughput: the block serves one request at a time; the next accept is possible no earlier than the cycle after the rsp handshake.
- Back-pressure: while rsp_ready = 0 in RESP, `rsp_data`, `rsp_id` and `rsp_err` are held stable and both readys stay 0.
- Reset values: FSM = IDLE, `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0, `rsp_err` = 0, `req*_ready` = 0, `acc` = 0, `last_grant` = 1.
- Reset mid-operation: the in-flight request is dropped with no response. Outputs go to their reset values immediately, without waiting for a clock edge.
- Outputs are registered except `req*_ready`, which is decoded from state and valids.

## Test plan
- req0 SHL a=0x81 amt=3 → rsp_data=0x08, id=0, err=0; rsp_valid after E+2. req0 SHR a=0x81 amt=7 → 0x01.
- req1 ROR a=0x96 amt=4 → 0x69, id=1, valid after E+3. ROL a=0x81 amt=1 → 0x03. ROL a=0x81 amt=0 → 0x81.
- ASR a=0x90 amt=2 → 0xE4. ASR a=0x70 amt=2 → 0x1C. ASR a=0x80 amt=7 → 0xFF.
- req0 and req1 both held valid, rsp_ready=1 → grant order 0,1,0,1. Only req1 valid → req1 granted every time.
- rsp_ready held 0 for 5 cycles in RESP → data and id stable, readys 0, then one handshake. Op 101 a=0xAA → rsp_data=0x00, err=1.
- rst_n low during PASS2 → rsp_valid=0 and outputs zero without a clock edge. After release with both valid → req0 accepted first.
